// File: rtl/sweep_ctrl_if.sv
// Host/counter-facing bundle for sweep_ctrl: start/abort handshake,
// sweep operands, status, and the drive/observe pair for the up/down counter.
interface sweep_ctrl_if #(
    parameter int WIDTH   = 8,
    parameter int LOOPS_W = 4
);
    logic               start;
    logic               abort;
    logic [WIDTH-1:0]   top;
    logic [LOOPS_W-1:0] loops;
    logic [WIDTH-1:0]   count;
    logic               cnt_rst;
    logic               cnt_up;
    logic               busy;
    logic               done;
    logic               aborted;
    logic [LOOPS_W-1:0] loops_left;

    modport master (
        output start, abort, top, loops, count,
        input  cnt_rst, cnt_up, busy, done, aborted, loops_left
    );

    modport slave (
        input  start, abort, top, loops, count,
        output cnt_rst, cnt_up, busy, done, aborted, loops_left
    );
endinterface

// File: rtl/sweep_ctrl.sv
// Triangle-sweep sequencer: steers an external up/down counter through
// 'loops' triangles of 0 -> top -> 0, holding it at 0 while idle.
module sweep_ctrl #(
    parameter int WIDTH   = 8,
    parameter int LOOPS_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    sweep_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   top_q, top_d;
    logic [LOOPS_W-1:0] loops_left_q, loops_left_d;
    logic               aborted_q, aborted_d;
    logic               cnt_rst_q, cnt_up_q, busy_q, done_q;
    logic [WIDTH-1:0]   top_m1;

    assign top_m1 = top_q - WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        top_d        = top_q;
        loops_left_d = loops_left_q;
        aborted_d    = aborted_q;
        case (state_q)
            IDLE: if (bus.start) begin
                aborted_d = 1'b0;
                if (bus.top != '0 && bus.loops != '0) begin
                    state_d      = UP;
                    top_d        = bus.top;
                    loops_left_d = bus.loops;
                end else begin
                    state_d = DONE;
                end
            end
            UP: if (bus.abort) begin
                state_d   = DONE;
                aborted_d = 1'b1;
            end else if (bus.count >= top_m1) begin
                // Counter steps onto top_q on this same edge.
                state_d = DOWN;
            end
            DOWN: if (bus.abort) begin
                state_d   = DONE;
                aborted_d = 1'b1;
            end else if (bus.count <= WIDTH'(1)) begin
                state_d      = (loops_left_q > LOOPS_W'(1)) ? UP : DONE;
                loops_left_d = (loops_left_q != '0) ? loops_left_q - LOOPS_W'(1) : loops_left_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            top_q        <= '0;
            loops_left_q <= '0;
            aborted_q    <= 1'b0;
            cnt_rst_q    <= 1'b1;
            cnt_up_q     <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            top_q        <= top_d;
            loops_left_q <= loops_left_d;
            aborted_q    <= aborted_d;
            cnt_rst_q    <= (state_d == IDLE) || (state_d == DONE);
            cnt_up_q     <= (state_d != DOWN);
            busy_q       <= (state_d == UP) || (state_d == DOWN);
            done_q       <= (state_d == DONE);
        end
    end

    assign bus.cnt_rst    = cnt_rst_q;
    assign bus.cnt_up     = cnt_up_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.aborted    = aborted_q;
    assign bus.loops_left = loops_left_q;
endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl, driving a behavioural up/down counter from
// the DUT's cnt_rst/cnt_up and checking the resulting sweep.
module tb_sweep_ctrl;
    localparam int WIDTH   = 8;
    localparam int LOOPS_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    sweep_ctrl_if #(.WIDTH(WIDTH), .LOOPS_W(LOOPS_W)) bus ();

    sweep_ctrl #(.WIDTH(WIDTH), .LOOPS_W(LOOPS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // The counter being sequenced: no hold state, reset value depends on direction.
    always_ff @(posedge clk) begin
        if (bus.cnt_rst) bus.count <= bus.cnt_up ? '0 : '1;
        else if (bus.cnt_up) bus.count <= bus.count + 8'd1;
        else bus.count <= bus.count - 8'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".cnt_rst"}, 32'(bus.cnt_rst), 1);
        check({tag, ".cnt_up"},  32'(bus.cnt_up), 1);
        check({tag, ".busy"},    32'(bus.busy), 0);
        check({tag, ".done"},    32'(bus.done), 0);
    endtask

    // Launch from IDLE and check every cycle of a full run to DONE then IDLE.
    task automatic run_tri(input int tp, input int lp, input string tag);
        bus.top   = tp[WIDTH-1:0];
        bus.loops = lp[LOOPS_W-1:0];
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int t = 0; t < lp; t++) begin
            for (int i = 0; i < 2 * tp; i++) begin
                check({tag, ".count"},      32'(bus.count), (i <= tp) ? i : 2 * tp - i);
                check({tag, ".cnt_up"},     32'(bus.cnt_up), (i < tp) ? 1 : 0);
                check({tag, ".cnt_rst"},    32'(bus.cnt_rst), 0);
                check({tag, ".busy"},       32'(bus.busy), 1);
                check({tag, ".done"},       32'(bus.done), 0);
                check({tag, ".loops_left"}, 32'(bus.loops_left), lp - t);
                step();
            end
        end
        check({tag, ".end_done"},  32'(bus.done), 1);
        check({tag, ".end_busy"},  32'(bus.busy), 0);
        check({tag, ".end_count"}, 32'(bus.count), 0);
        check({tag, ".end_left"},  32'(bus.loops_left), 0);
        check({tag, ".end_abrt"},  32'(bus.aborted), 0);
        step();
        check_idle({tag, ".idle"});
        check({tag, ".idle_count"}, 32'(bus.count), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.top   = '0;
        bus.loops = '0;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_idle("reset");
        check("reset.loops_left", 32'(bus.loops_left), 0);
        check("reset.aborted",    32'(bus.aborted), 0);
        check("reset.count",      32'(bus.count), 0);

        run_tri(3, 2, "t3l2");
        run_tri(1, 3, "t1l3");

        // Degenerate starts: one-cycle done, no sweep.
        bus.top = 8'd0; bus.loops = 4'd2; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("deg_top.done",  32'(bus.done), 1);
        check("deg_top.busy",  32'(bus.busy), 0);
        check("deg_top.count", 32'(bus.count), 0);
        step();
        check_idle("deg_top.idle");
        check("deg_top.count2", 32'(bus.count), 0);

        bus.top = 8'd5; bus.loops = 4'd0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("deg_loops.done",  32'(bus.done), 1);
        check("deg_loops.busy",  32'(bus.busy), 0);
        check("deg_loops.count", 32'(bus.count), 0);
        step();
        check_idle("deg_loops.idle");

        run_tri(255, 1, "t255");

        // Abort while rising at count=5; a start during UP must be ignored.
        bus.top = 8'd10; bus.loops = 4'd2; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.top = 8'd1; bus.loops = 4'd1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("abort.ign_busy",  32'(bus.busy), 1);
        check("abort.ign_left",  32'(bus.loops_left), 2);
        check("abort.ign_count", 32'(bus.count), 3);
        step();
        step();
        check("abort.pre_count", 32'(bus.count), 5);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort.done",    32'(bus.done), 1);
        check("abort.busy",    32'(bus.busy), 0);
        check("abort.aborted", 32'(bus.aborted), 1);
        check("abort.count",   32'(bus.count), 6);
        check("abort.left",    32'(bus.loops_left), 2);
        step();
        check_idle("abort.idle");
        check("abort.count0",   32'(bus.count), 0);
        check("abort.sticky",   32'(bus.aborted), 1);
        run_tri(1, 1, "restart");

        // Reset mid-DOWN.
        bus.top = 8'd4; bus.loops = 4'd1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("rstmid.pre_count", 32'(bus.count), 3);
        check("rstmid.pre_up",    32'(bus.cnt_up), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("rstmid.idle");
        check("rstmid.left",  32'(bus.loops_left), 0);
        check("rstmid.count", 32'(bus.count), 2);
        step();
        check("rstmid.count0", 32'(bus.count), 0);
        run_tri(2, 2, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
